// File: rtl/goose_collision_ctrl_pkg.sv
// Shared definitions for the goose collision controller: game states and
// default geometry/score parameters.
package goose_collision_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    HIT     = 3'd2,
    OVER    = 3'd3,
    RESTART = 3'd4
  } state_t;

  localparam int H_ACTIVE_DEF   = 640;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int HIT_THRESH_DEF = 4;
  localparam int SCORE_DIV_DEF  = 6;
  localparam int SCORE_W_DEF    = 32;

endpackage

// File: rtl/goose_collision_ctrl_if.sv
// Pixel/button bus between the scan source, sprite renderers and the
// collision controller, plus the controller's game outputs.
interface goose_collision_ctrl_if #(
  parameter int SCORE_W = goose_collision_ctrl_pkg::SCORE_W_DEF
);
  logic [9:0]         x;
  logic [9:0]         y;
  logic               goose;
  logic               bean;
  logic [1:0]         button;
  logic               stop;
  logic               restart;
  logic [SCORE_W-1:0] score;
  logic [2:0]         state;

  modport master (
    output x, y, goose, bean, button,
    input  stop, restart, score, state
  );

  modport slave (
    input  x, y, goose, bean, button,
    output stop, restart, score, state
  );
endinterface

// File: rtl/goose_collision_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level followed by a
// rising-edge detector producing a registered one-clock pulse.
module goose_collision_ctrl_btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] settle;

  // Synchronise the level, remember the previous synchronised level, and
  // only emit edges once the pipeline has refilled with the real button
  // level after reset, so a button held through reset never looks pressed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev   <= 1'b0;
      settle <= 2'd0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      if (settle != 2'd3) begin
        settle <= settle + 2'd1;
      end
      pulse <= (settle == 2'd3) && sync2 && !prev;
    end
  end

endmodule

// File: rtl/goose_collision_ctrl.sv
// Goose/bean collision controller: counts per-frame sprite overlap, runs
// the game state machine, drives obstacle stop/restart and keeps the score.
module goose_collision_ctrl
  import goose_collision_ctrl_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int HIT_THRESH = HIT_THRESH_DEF,
  parameter int SCORE_DIV  = SCORE_DIV_DEF,
  parameter int SCORE_W    = SCORE_W_DEF
) (
  input logic clk,
  input logic reset,
  goose_collision_ctrl_if.slave bus
);

  localparam int FRM_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  logic [9:0]         x1;
  logic [9:0]         y1;
  logic               goose1;
  logic               bean1;
  logic               fe_q;
  logic               frame_end;
  logic               overlap;
  logic               start_p;
  logic               restart_p;
  logic [2:0]         ov_cnt;
  logic [FRM_W-1:0]   frm_cnt;
  logic [SCORE_W-1:0] score_q;
  state_t             state_q;
  logic               stop_q;
  logic               restart_q;

  goose_collision_ctrl_btn_sync_edge u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.button[0]),
    .pulse (start_p)
  );

  goose_collision_ctrl_btn_sync_edge u_restart (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.button[1]),
    .pulse (restart_p)
  );

  assign frame_end = (x1 == 10'd0) && (y1 == 10'(V_ACTIVE));
  assign overlap   = goose1 && bean1 && (x1 < 10'(H_ACTIVE)) && (y1 < 10'(V_ACTIVE));

  // Register the scan position and sprite flags once, and register the
  // frame-end marker so the state machine acts one clock later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x1     <= 10'd0;
      y1     <= 10'd0;
      goose1 <= 1'b0;
      bean1  <= 1'b0;
      fe_q   <= 1'b0;
    end else begin
      x1     <= bus.x;
      y1     <= bus.y;
      goose1 <= bus.goose;
      bean1  <= bus.bean;
      fe_q   <= frame_end;
    end
  end

  // Count overlapping pixels of the current frame while running, saturating
  // at the hit threshold; the frame boundary always clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ov_cnt <= 3'd0;
    end else if (fe_q || (state_q == OVER && restart_p)) begin
      ov_cnt <= 3'd0;
    end else if (state_q == RUN && overlap && ov_cnt < 3'(HIT_THRESH)) begin
      ov_cnt <= ov_cnt + 3'd1;
    end
  end

  // Game state machine with registered stop/restart, frame-of-survival
  // divider and saturating score.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      stop_q    <= 1'b1;
      restart_q <= 1'b0;
      score_q   <= '0;
      frm_cnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_p) begin
            state_q <= RUN;
            stop_q  <= 1'b0;
          end
        end
        RUN: begin
          if (fe_q) begin
            if (ov_cnt >= 3'(HIT_THRESH)) begin
              state_q <= HIT;
              stop_q  <= 1'b1;
            end else if (frm_cnt == FRM_W'(SCORE_DIV - 1)) begin
              frm_cnt <= '0;
              if (score_q != '1) begin
                score_q <= score_q + SCORE_W'(1);
              end
            end else begin
              frm_cnt <= frm_cnt + FRM_W'(1);
            end
          end
        end
        HIT: begin
          if (fe_q) begin
            state_q <= OVER;
          end
        end
        OVER: begin
          if (restart_p) begin
            state_q   <= RESTART;
            restart_q <= 1'b1;
            score_q   <= '0;
            frm_cnt   <= '0;
          end
        end
        RESTART: begin
          if (fe_q) begin
            state_q   <= IDLE;
            restart_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          stop_q    <= 1'b1;
          restart_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stop    = stop_q;
  assign bus.restart = restart_q;
  assign bus.score   = score_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_goose_collision_ctrl.sv
// Self-checking bench for goose_collision_ctrl: scans a reduced frame with
// random sprite noise and placed overlaps, and compares against a
// frame-level game model.
module tb_goose_collision_ctrl;

  localparam int HA = 16;
  localparam int VA = 8;
  localparam int HT = 20;
  localparam int VT = 10;
  localparam int TH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  goose_collision_ctrl_if #(.SCORE_W(32)) bus ();
  goose_collision_ctrl_if #(.SCORE_W(3))  bus2 ();

  goose_collision_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .HIT_THRESH(TH), .SCORE_DIV(6), .SCORE_W(32)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  goose_collision_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .HIT_THRESH(TH), .SCORE_DIV(1), .SCORE_W(3)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level game model: 0 idle, 1 run, 2 hit, 3 over, 4 restart.
  int     m_state[2];
  longint m_score[2];
  int     m_frames[2];
  int     m_div[2]  = '{6, 1};
  longint m_smax[2] = '{64'hFFFF_FFFF, 7};
  logic [1:0] btn_cur[2];

  // Snapshots taken while a frame is scanned (dut unless noted).
  logic [2:0]  s_lat_state[3];
  logic        s_lat_stop[3];
  logic        s_lat_restart[3];
  int          e_old_state, e_new_state;
  logic [2:0]  s_mid_state;
  logic        s_mid_stop, s_mid_restart;
  logic [31:0] s_mid_score;
  int          e_mid_state;
  longint      e_mid_score;
  logic [2:0]  s_press_state;
  int          e_press_state;

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k]  = 0;
      m_score[k]  = 0;
      m_frames[k] = 0;
    end
  endfunction

  function automatic void model_press(input int k, input logic [1:0] ev);
    if (m_state[k] == 0 && ev[0]) m_state[k] = 1;
    else if (m_state[k] == 3 && ev[1]) begin
      m_state[k]  = 4;
      m_score[k]  = 0;
      m_frames[k] = 0;
    end
  endfunction

  function automatic void model_frame_end(input int k, input int n_ov);
    case (m_state[k])
      1: begin
        if (n_ov >= TH) m_state[k] = 2;
        else begin
          m_frames[k]++;
          if (m_frames[k] == m_div[k]) begin
            m_frames[k] = 0;
            if (m_score[k] < m_smax[k]) m_score[k]++;
          end
        end
      end
      2: m_state[k] = 3;
      4: m_state[k] = 0;
      default: ;
    endcase
  endfunction

  function automatic logic exp_stop(input int s);
    return (s != 1);
  endfunction

  function automatic logic exp_restart(input int s);
    return (s == 4);
  endfunction

  // Scan one full frame; n_ov overlaps placed in the active area, optional
  // button press at row 1 on target tgt, optional reset at row rst_row.
  task automatic run_frame(input int n_ov, input int tgt, input logic [1:0] press,
                           input int hold, input int rst_row);
    bit ov_map[VA][HA];
    int placed = 0;
    int age = -1;
    int hold_left = 0;
    int rst_left = 0;
    logic g, b;
    logic [1:0] ev;
    for (int r = 0; r < VA; r++) for (int c = 0; c < HA; c++) ov_map[r][c] = 1'b0;
    while (placed < n_ov) begin
      int px = $urandom_range(HA - 1);
      int py = $urandom_range(VA - 1);
      if (!ov_map[py][px]) begin
        ov_map[py][px] = 1'b1;
        placed++;
      end
    end
    for (int yy = 0; yy < VT; yy++) begin
      for (int xx = 0; xx < HT; xx++) begin
        @(negedge clk);
        if (age >= 0) begin
          age++;
          if (age == 4) begin
            s_press_state = (tgt == 0) ? bus.state : bus2.state;
            e_press_state = m_state[tgt];
          end
        end
        if (yy == VA && xx >= 1 && xx <= 3) begin
          s_lat_state[xx-1]   = bus.state;
          s_lat_stop[xx-1]    = bus.stop;
          s_lat_restart[xx-1] = bus.restart;
        end
        if (yy == VA - 1 && xx == 0) begin
          s_mid_state   = bus.state;
          s_mid_stop    = bus.stop;
          s_mid_restart = bus.restart;
          s_mid_score   = bus.score;
          e_mid_state   = m_state[0];
          e_mid_score   = m_score[0];
        end
        if (yy == 1 && xx == 0 && press != 2'b00) begin
          ev = press & ~btn_cur[tgt];
          btn_cur[tgt] = btn_cur[tgt] | press;
          model_press(tgt, ev);
          age = 0;
          hold_left = hold;
        end else if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) btn_cur[tgt] = btn_cur[tgt] & ~press;
        end
        if (yy == rst_row && xx == 0) begin
          reset = 1'b0;
          model_reset();
          rst_left = 3;
        end else if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0) reset = 1'b1;
        end
        if (yy < VA && xx < HA) begin
          if (ov_map[yy][xx]) begin
            g = 1'b1;
            b = 1'b1;
          end else begin
            int r = $urandom_range(3);
            g = (r == 1);
            b = (r == 2);
          end
        end else begin
          g = 1'($urandom_range(1));
          b = 1'($urandom_range(1));
        end
        bus.x = 10'(xx);   bus2.x = 10'(xx);
        bus.y = 10'(yy);   bus2.y = 10'(yy);
        bus.goose = g;     bus2.goose = g;
        bus.bean = b;      bus2.bean = b;
        bus.button = btn_cur[0];
        bus2.button = btn_cur[1];
        if (yy == VA && xx == 0) begin
          e_old_state = m_state[0];
          for (int k = 0; k < 2; k++) model_frame_end(k, n_ov);
          e_new_state = m_state[0];
        end
      end
    end
  endtask

  task automatic test_reset();
    bus.x = '0; bus.y = '0; bus.goose = 1'b0; bus.bean = 1'b0; bus.button = 2'b00;
    bus2.x = '0; bus2.y = '0; bus2.goose = 1'b0; bus2.bean = 1'b0; bus2.button = 2'b00;
    btn_cur[0] = 2'b00;
    btn_cur[1] = 2'b00;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.stop !== 1'b1) begin errors++; $display("[TB] FAIL reset_stop: got %b want 1", bus.stop); end
    checks++; if (bus.restart !== 1'b0) begin errors++; $display("[TB] FAIL reset_restart: got %b want 0", bus.restart); end
    checks++; if (bus.score !== 32'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d want 0", bus.score); end
    for (int f = 0; f < 2; f++) begin
      run_frame(0, 0, 2'b00, 0, -1);
      checks++; if (bus.state !== 3'd0 || bus.stop !== 1'b1 || bus.restart !== 1'b0 || bus.score !== 32'd0) begin
        errors++;
        $display("[TB] FAIL idle_hold frame %0d: got state=%0d stop=%b restart=%b score=%0d want 0/1/0/0",
                 f, bus.state, bus.stop, bus.restart, bus.score);
      end
    end
  endtask

  task automatic test_start_and_score();
    run_frame(0, 0, 2'b01, 10, -1);
    checks++; if (s_press_state !== 3'(e_press_state)) begin errors++; $display("[TB] FAIL start_latency: got %0d want %0d", s_press_state, e_press_state); end
    checks++; if (bus.stop !== 1'b0) begin errors++; $display("[TB] FAIL run_stop: got %b want 0", bus.stop); end
    for (int f = 0; f < 11; f++) begin
      run_frame(0, 0, 2'b00, 0, -1);
      checks++; if (bus.state !== 3'(m_state[0]) || bus.score !== 32'(m_score[0])) begin
        errors++;
        $display("[TB] FAIL run_score frame %0d: got state=%0d score=%0d want %0d/%0d",
                 f, bus.state, bus.score, m_state[0], m_score[0]);
      end
    end
    checks++; if (bus.score !== 32'd2) begin errors++; $display("[TB] FAIL score_after_12: got %0d want 2", bus.score); end
  endtask

  task automatic test_hit();
    run_frame(3, 0, 2'b00, 0, -1);
    checks++; if (bus.state !== 3'(m_state[0]) || bus.stop !== 1'b0) begin
      errors++; $display("[TB] FAIL below_thresh: got state=%0d stop=%b want %0d/0", bus.state, bus.stop, m_state[0]);
    end
    run_frame(5, 0, 2'b00, 0, -1);
    for (int i = 0; i < 3; i++) begin
      int want = (i < 2) ? e_old_state : e_new_state;
      checks++; if (s_lat_stop[i] !== exp_stop(want) || s_lat_state[i] !== 3'(want)) begin
        errors++;
        $display("[TB] FAIL hit_latency clk %0d: got stop=%b state=%0d want %b/%0d",
                 i + 1, s_lat_stop[i], s_lat_state[i], exp_stop(want), want);
      end
    end
    checks++; if (bus.state !== 3'd2) begin errors++; $display("[TB] FAIL hit_state: got %0d want 2", bus.state); end
    run_frame(0, 0, 2'b00, 0, -1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("[TB] FAIL over_state: got %0d want 3", bus.state); end
    run_frame(0, 0, 2'b01, 3, -1);
    checks++; if (s_press_state !== 3'(e_press_state) || bus.state !== 3'd3 || bus.score !== 32'(m_score[0])) begin
      errors++;
      $display("[TB] FAIL over_ignores_start: got state=%0d score=%0d want 3/%0d", bus.state, bus.score, m_score[0]);
    end
  endtask

  task automatic test_restart();
    run_frame(0, 0, 2'b11, 3, -1);
    checks++; if (s_mid_state !== 3'(e_mid_state) || s_mid_restart !== exp_restart(e_mid_state) ||
                  s_mid_stop !== exp_stop(e_mid_state) || s_mid_score !== 32'(e_mid_score)) begin
      errors++;
      $display("[TB] FAIL restart_mid: got state=%0d restart=%b stop=%b score=%0d want %0d/%b/%b/%0d",
               s_mid_state, s_mid_restart, s_mid_stop, s_mid_score, e_mid_state,
               exp_restart(e_mid_state), exp_stop(e_mid_state), e_mid_score);
    end
    for (int i = 0; i < 3; i++) begin
      int want = (i < 2) ? e_old_state : e_new_state;
      checks++; if (s_lat_restart[i] !== exp_restart(want) || s_lat_state[i] !== 3'(want)) begin
        errors++;
        $display("[TB] FAIL restart_release clk %0d: got restart=%b state=%0d want %b/%0d",
                 i + 1, s_lat_restart[i], s_lat_state[i], exp_restart(want), want);
      end
    end
    checks++; if (bus.state !== 3'd0 || bus.restart !== 1'b0 || bus.score !== 32'd0) begin
      errors++; $display("[TB] FAIL restart_done: got state=%0d restart=%b score=%0d want 0/0/0", bus.state, bus.restart, bus.score);
    end
  endtask

  task automatic test_saturation();
    run_frame(0, 0, 2'b01, 4, -1);
    run_frame(0, 0, 2'b10, 4, -1);
    checks++; if (s_press_state !== 3'(e_press_state) || bus.state !== 3'd1) begin
      errors++; $display("[TB] FAIL run_ignores_restart: got %0d want 1", bus.state);
    end
    run_frame(0, 1, 2'b01, 4, -1);
    for (int f = 0; f < 13; f++) begin
      run_frame(0, 0, 2'b00, 0, -1);
      checks++; if (bus2.score !== 3'(m_score[1]) || bus2.state !== 3'(m_state[1])) begin
        errors++;
        $display("[TB] FAIL sat_score frame %0d: got score=%0d state=%0d want %0d/%0d",
                 f, bus2.score, bus2.state, m_score[1], m_state[1]);
      end
    end
    checks++; if (bus2.score !== 3'b111) begin errors++; $display("[TB] FAIL sat_all_ones: got %0d want 7", bus2.score); end
    checks++; if (bus.score !== 32'(m_score[0]) || bus.state !== 3'd1) begin
      errors++; $display("[TB] FAIL main_score: got %0d/%0d want %0d/1", bus.score, bus.state, m_score[0]);
    end
  endtask

  task automatic test_reset_in_restart();
    run_frame(5, 0, 2'b00, 0, -1);
    run_frame(0, 0, 2'b00, 0, -1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("[TB] FAIL pre_over: got %0d want 3", bus.state); end
    run_frame(0, 0, 2'b11, -1, 3);
    checks++; if (s_mid_state !== 3'd0 || s_mid_restart !== 1'b0 || s_mid_stop !== 1'b1 || s_mid_score !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got state=%0d restart=%b stop=%b score=%0d want 0/0/1/0",
               s_mid_state, s_mid_restart, s_mid_stop, s_mid_score);
    end
    run_frame(0, 0, 2'b00, 0, -1);
    checks++; if (bus.state !== 3'd0 || bus.restart !== 1'b0) begin
      errors++; $display("[TB] FAIL held_no_pulse: got state=%0d restart=%b want 0/0", bus.state, bus.restart);
    end
    btn_cur[0] = 2'b00;
    run_frame(0, 0, 2'b10, 3, -1);
    checks++; if (bus.state !== 3'(m_state[0]) || bus.restart !== 1'b0) begin
      errors++; $display("[TB] FAIL idle_restart: got state=%0d restart=%b want %0d/0", bus.state, bus.restart, m_state[0]);
    end
    run_frame(0, 0, 2'b01, 3, -1);
    checks++; if (bus.state !== 3'(m_state[0]) || bus.stop !== exp_stop(m_state[0])) begin
      errors++; $display("[TB] FAIL start_after_reset: got state=%0d stop=%b want %0d", bus.state, bus.stop, m_state[0]);
    end
  endtask

  initial begin
    test_reset();
    test_start_and_score();
    test_hit();
    test_restart();
    test_saturation();
    test_reset_in_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
